// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point helpers and types for the feature engine.
// FE_SATURATE_EN selects clamping instead of wrapping in fxp_red().
package fxp_pkg;

    typedef enum logic [1:0] {NONE = 2'b00, UP = 2'b01, DOWN = 2'b10} fe_cross_t;

    typedef struct packed {
        logic primed;
        logic above;
    } fe_flags_t;

    // Values arrive sign-extended to 64 bits; w is the target width (w <= 62).
    function automatic logic signed [63:0] fxp_sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return x > hi ? hi : x < lo ? lo : x;
    endfunction

    function automatic logic signed [63:0] fxp_wrap(input logic signed [63:0] x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic logic signed [63:0] fxp_red(input logic signed [63:0] x, input int w);
`ifdef FE_SATURATE_EN
        return fxp_sat(x, w);
`else
        return fxp_wrap(x, w);
`endif
    endfunction

endpackage

// File: rtl/fe_ema_update.sv
// fe_ema_update: one EMA step, ema' = ema + ((ret - ema) >>> SHIFT).
// The saturation flag port exists only with FE_SATURATE_EN.
module fe_ema_update
    import fxp_pkg::*;
#(
    parameter int W     = 32,
    parameter int SHIFT = 2
) (
    input  logic signed [W-1:0] ema_i,
    input  logic signed [W-1:0] ret_i,
    output logic signed [W-1:0] ema_o
`ifdef FE_SATURATE_EN
    ,
    output logic                sat_o
`endif
);
    logic signed [63:0] dx, dr, sx, sr;
    logic signed [W-1:0] step;

    always_comb begin
        dx    = 64'(ret_i) - 64'(ema_i);
        dr    = fxp_red(dx, W);
        step  = W'(dr >>> SHIFT);
        sx    = 64'(ema_i) + 64'(step);
        sr    = fxp_red(sx, W);
        ema_o = W'(sr);
`ifdef FE_SATURATE_EN
        sat_o = (dr != dx) || (sr != sx);
`endif
    end

endmodule

// File: rtl/feature_engine_mc.sv
// feature_engine_mc: per-channel return, fast/slow EMA, warm-up and crossover extractor.
// Define FE_SATURATE_EN for clamped arithmetic and the sat_out port.
module feature_engine_mc
    import fxp_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int W          = 32,
    parameter int FRAC       = 16,
    parameter int FAST_SHIFT = 2,
    parameter int SLOW_SHIFT = 5,
    parameter int WARMUP     = 2,
    localparam int CW        = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_chan,
    input  logic signed [W-1:0] price_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_chan,
    output logic signed [W-1:0] ret_out,
    output logic signed [W-1:0] ema_fast_out,
    output logic signed [W-1:0] ema_slow_out,
    output logic                warm_out,
    output logic [1:0]          cross_out,
    output logic                chan_err
`ifdef FE_SATURATE_EN
    ,
    output logic                sat_out
`endif
);
    localparam int CNTW = $clog2(WARMUP + 1);

    logic signed [W-1:0] prev_q [CHANNELS];
    logic signed [W-1:0] emaf_q [CHANNELS];
    logic signed [W-1:0] emas_q [CHANNELS];
    fe_flags_t           flg_q  [CHANNELS];
    logic [CNTW-1:0]     cnt_q  [CHANNELS];

    logic                ov_q, warm_q, err_q;
    logic [CW-1:0]       chan_q;
    logic signed [W-1:0] ret_q, ef_q, es_q;
    fe_cross_t           cross_q;

    logic                acc, ok, new_above, warm_d;
    logic [CW-1:0]       idx;
    logic signed [W-1:0] p_cur, ef_cur, es_cur, ret_n, ef_n, es_n, ret_d, ef_d, es_d;
    logic signed [63:0]  rx, rr;
    fe_flags_t           fl_cur, fl_d;
    logic [CNTW-1:0]     cnt_cur, cnt_d;
    fe_cross_t           cross_d;

`ifdef FE_SATURATE_EN
    logic sat_f, sat_s, sat_q, sat_d;
`endif

    assign in_ready = !ov_q || out_ready;

    // A same-cycle clr makes the sample see a freshly cleared channel.
    always_comb begin
        acc       = in_valid && in_ready;
        ok        = {1'b0, in_chan} < (CW + 1)'(CHANNELS);
        idx       = ok ? in_chan : '0;
        p_cur     = clr ? '0 : prev_q[idx];
        ef_cur    = clr ? '0 : emaf_q[idx];
        es_cur    = clr ? '0 : emas_q[idx];
        fl_cur    = clr ? '0 : flg_q[idx];
        cnt_cur   = clr ? '0 : cnt_q[idx];
        rx        = 64'(price_in) - 64'(p_cur);
        rr        = fxp_red(rx, W);
        ret_n     = W'(rr);
        cnt_d     = cnt_cur == CNTW'(WARMUP) ? cnt_cur : cnt_cur + 1'b1;
        warm_d    = cnt_d == CNTW'(WARMUP);
        new_above = ef_n > es_n;
        ret_d     = fl_cur.primed ? ret_n : '0;
        ef_d      = fl_cur.primed ? ef_n : ef_cur;
        es_d      = fl_cur.primed ? es_n : es_cur;
        fl_d      = '{primed: 1'b1, above: fl_cur.primed ? new_above : fl_cur.above};
        cross_d   = !fl_cur.primed || !warm_d ? NONE :
                    (!fl_cur.above && new_above) ? UP :
                    (fl_cur.above && !new_above) ? DOWN : NONE;
`ifdef FE_SATURATE_EN
        sat_d     = fl_cur.primed && ((rr != rx) || sat_f || sat_s);
`endif
    end

    fe_ema_update #(.W(W), .SHIFT(FAST_SHIFT)) u_fast (
        .ema_i(ef_cur), .ret_i(ret_n), .ema_o(ef_n)
`ifdef FE_SATURATE_EN
        , .sat_o(sat_f)
`endif
    );

    fe_ema_update #(.W(W), .SHIFT(SLOW_SHIFT)) u_slow (
        .ema_i(es_cur), .ret_i(ret_n), .ema_o(es_n)
`ifdef FE_SATURATE_EN
        , .sat_o(sat_s)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                prev_q[c] <= '0;
                emaf_q[c] <= '0;
                emas_q[c] <= '0;
                flg_q[c]  <= '0;
                cnt_q[c]  <= '0;
            end
            ov_q    <= 1'b0;
            chan_q  <= '0;
            ret_q   <= '0;
            ef_q    <= '0;
            es_q    <= '0;
            warm_q  <= 1'b0;
            cross_q <= NONE;
            err_q   <= 1'b0;
`ifdef FE_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            if (clr) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    prev_q[c] <= '0;
                    emaf_q[c] <= '0;
                    emas_q[c] <= '0;
                    flg_q[c]  <= '0;
                    cnt_q[c]  <= '0;
                end
            end
            if (acc && !ok) err_q <= 1'b1;
            if (acc && ok) begin
                prev_q[idx] <= fl_cur.primed ? p_cur : price_in;
                emaf_q[idx] <= ef_d;
                emas_q[idx] <= es_d;
                flg_q[idx]  <= fl_d;
                cnt_q[idx]  <= cnt_d;
                ov_q        <= 1'b1;
                chan_q      <= in_chan;
                ret_q       <= ret_d;
                ef_q        <= ef_d;
                es_q        <= es_d;
                warm_q      <= warm_d;
                cross_q     <= cross_d;
`ifdef FE_SATURATE_EN
                sat_q       <= sat_d;
`endif
                if (fl_cur.primed) prev_q[idx] <= price_in;
            end else if (out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign out_valid    = ov_q;
    assign out_chan     = chan_q;
    assign ret_out      = ret_q;
    assign ema_fast_out = ef_q;
    assign ema_slow_out = es_q;
    assign warm_out     = warm_q;
    assign cross_out    = cross_q;
    assign chan_err     = err_q;
`ifdef FE_SATURATE_EN
    assign sat_out      = sat_q;
`endif

endmodule

// File: tb/tb_feature_engine_mc.sv
// tb_feature_engine_mc: directed checks of feature_engine_mc with CHANNELS=5.
// Honours FE_SATURATE_EN for the saturation vector and the sat_out port.
module tb_feature_engine_mc;
    localparam int CH = 5, W = 32, FS = 2, SS = 5, WU = 2, CW = 3;

    logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 1;
    logic [CW-1:0] in_chan = '0;
    logic [W-1:0]  price_in = '0;
    logic          in_ready, out_valid, warm_out, chan_err;
    logic [CW-1:0] out_chan;
    logic [W-1:0]  ret_out, ema_fast_out, ema_slow_out;
    logic [1:0]    cross_out;
`ifdef FE_SATURATE_EN
    logic          sat_out;
`endif

    int total = 0, bad = 0;

    typedef struct {
        int         c;
        logic [31:0] r, f, s;
        logic       w;
        logic [1:0] x;
    } exp_t;

    exp_t   q[$];
    longint mprev[CH], mef[CH], mes[CH];
    bit     mprim[CH], mabove[CH];
    int     mcnt[CH];

    feature_engine_mc #(.CHANNELS(CH), .W(W), .FRAC(16), .FAST_SHIFT(FS), .SLOW_SHIFT(SS), .WARMUP(WU)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_chan(in_chan), .price_in(price_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .ret_out(ret_out), .ema_fast_out(ema_fast_out),
        .ema_slow_out(ema_slow_out), .warm_out(warm_out), .cross_out(cross_out),
        .chan_err(chan_err)
`ifdef FE_SATURATE_EN
        , .sat_out(sat_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint red(input longint x);
`ifdef FE_SATURATE_EN
        return x > 64'sd2147483647 ? 64'sd2147483647 : x < -64'sd2147483648 ? -64'sd2147483648 : x;
`else
        return (x <<< 32) >>> 32;
`endif
    endfunction

    function automatic void mclear();
        for (int c = 0; c < CH; c++) begin
            mprev[c] = 0; mef[c] = 0; mes[c] = 0; mprim[c] = 0; mabove[c] = 0; mcnt[c] = 0;
        end
    endfunction

    function automatic exp_t model(input int c, input longint p);
        exp_t   e;
        longint r, f, s;
        bit     na;
        e.c = c;
        mcnt[c]++;
        e.w = mcnt[c] >= WU;
        if (!mprim[c]) begin
            mprim[c] = 1; mprev[c] = p;
            e.r = 0; e.f = 32'(mef[c]); e.s = 32'(mes[c]); e.x = 2'b00;
            return e;
        end
        r = red(p - mprev[c]);
        f = red(mef[c] + (red(r - mef[c]) >>> FS));
        s = red(mes[c] + (red(r - mes[c]) >>> SS));
        na = f > s;
        e.x = !e.w ? 2'b00 : (!mabove[c] && na) ? 2'b01 : (mabove[c] && !na) ? 2'b10 : 2'b00;
        mabove[c] = na; mprev[c] = p; mef[c] = f; mes[c] = s;
        e.r = 32'(r); e.f = 32'(f); e.s = 32'(s);
        return e;
    endfunction

    task automatic push(input int c, input logic [31:0] p, input bit cl = 0);
        @(negedge clk);
        in_valid = 1; in_chan = CW'(c); price_in = p; clr = cl;
        @(posedge clk);
        #1;
        in_valid = 0; clr = 0;
    endtask

    // Interleaves chans 0/2 through the model; the stalled variant also checks hold stability.
    task automatic run(input bit stall, input longint base);
        int          i = 0, cyc = 0;
        exp_t        e, h;
        logic [31:0] sr;
        logic [CW-1:0] sc;
        bit          held = 0;
        while ((i < 8 || q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            out_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            in_valid  = i < 8;
            in_chan   = (i % 2) ? 3'd2 : 3'd0;
            price_in  = 32'((i % 2) ? base - longint'(i) * 'h6000 : base + longint'(i) * 'h11000);
            #1;
            if (held) begin
                chk("stall_ret", ret_out, sr);
                chk("stall_chan", out_chan, sc);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            held = out_valid && !out_ready; sr = ret_out; sc = out_chan;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("dup_output", 1, 0);
                else begin
                    h = q.pop_front();
                    chk("s_chan", out_chan, h.c);
                    chk("s_ret", ret_out, h.r);
                    chk("s_fast", ema_fast_out, h.f);
                    chk("s_slow", ema_slow_out, h.s);
                    chk("s_warm", warm_out, h.w);
                    chk("s_cross", cross_out, h.x);
                end
            end
            if (in_valid && in_ready) begin
                e = model(int'(in_chan), longint'($signed(price_in)));
                q.push_back(e);
                i++;
            end
            cyc++;
        end
        in_valid = 0; out_ready = 1;
        chk("stream_drain", q.size(), 0);
        chk("stream_sent", i, 8);
    endtask

    initial begin
        mclear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ret", ret_out, 0);
        chk("rst_cross", cross_out, 0);
        chk("rst_chan_err", chan_err, 0);
`ifdef FE_SATURATE_EN
        chk("rst_sat", sat_out, 0);
`endif
        rst = 0;

        push(0, 32'h00010000);
        chk("c0a_valid", out_valid, 1);
        chk("c0a_ret", ret_out, 0);
        chk("c0a_fast", ema_fast_out, 0);
        chk("c0a_warm", warm_out, 0);
        push(0, 32'h00030000);
        chk("c0b_ret", ret_out, 32'h00020000);
        chk("c0b_fast", ema_fast_out, 32'h00008000);
        chk("c0b_slow", ema_slow_out, 32'h00001000);
        chk("c0b_warm", warm_out, 1);

        push(1, 32'h0);
        chk("x1_cross", cross_out, 2'b00);
        push(1, 32'h00010000);
        chk("x2_cross", cross_out, 2'b01);
        chk("x2_fast", ema_fast_out, 32'h00004000);
        chk("x2_slow", ema_slow_out, 32'h00000800);
        push(1, 32'h0);
        chk("x3_cross", cross_out, 2'b10);
        chk("x3_fast", ema_fast_out, 32'hFFFFF000);
        chk("x3_slow", ema_slow_out, 32'hFFFFFFC0);
        chk("x3_chan", out_chan, 1);

        push(3, 32'h7FFF0000);
        push(3, 32'h80000000);
`ifdef FE_SATURATE_EN
        chk("sat_ret", ret_out, 32'h80000000);
        chk("sat_flag", sat_out, 1);
`else
        chk("wrap_ret", ret_out, 32'h00010000);
`endif

        push(5, 32'h12345678);
        chk("oor_valid", out_valid, 0);
        chk("oor_err", chan_err, 1);
        push(0, 32'h00050000);
        chk("oor_next_valid", out_valid, 1);
        chk("oor_next_ret", ret_out, 32'h00020000);
        chk("oor_next_fast", ema_fast_out, 32'h0000E000);
        chk("oor_err_sticky", chan_err, 1);

        @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        mclear();
        run(0, 64'sh00100000);
        run(1, 64'sh00200000);

        push(0, 32'h00400000, 1);
        chk("clr_ret", ret_out, 0);
        chk("clr_warm", warm_out, 0);
        chk("clr_err_kept", chan_err, 1);
        push(2, 32'h00410000);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ret", ret_out, 0);
        chk("mid_rst_err", chan_err, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 0;
        push(2, 32'h12340000);
        chk("post_rst_c2_ret", ret_out, 0);
        chk("post_rst_c2_warm", warm_out, 0);
        push(0, 32'h00005000);
        chk("post_rst_c0_ret", ret_out, 0);
        chk("post_rst_c0_warm", warm_out, 0);
        chk("post_rst_c0_chan", out_chan, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/feature_engine_mc.md
# feature_engine_mc

Multi-channel, parametrised successor to the single-stream return/EMA feature extractor. Accepts channel-tagged price samples in signed fixed point. Per channel it computes the return (price delta), a fast and a slow EMA of returns, a warm-up indicator and a fast/slow crossover event. It sits between the market-data decoder and the signal/scoring stage, with one valid/ready stream in and one out.

## Interface
- `CHANNELS`, 4: number of independent instruments, ≥1, need not be a power of two
- `W`, 32: sample and feature width, signed
- `FRAC`, 16: fractional bits; documentation only, arithmetic is format-agnostic
- `FAST_SHIFT`, 2: fast EMA alpha = 2^-FAST_SHIFT
- `SLOW_SHIFT`, 5: slow EMA alpha = 2^-SLOW_SHIFT; must exceed `FAST_SHIFT`
- `WARMUP`, 2: samples per channel before features are flagged warm, ≥1
- `clk` in 1: single clock; all logic is rising-edge
- `rst` in 1: asynchronous, active-high reset
- `clr` in 1: synchronous pulse that clears all per-channel state
- `in_valid` in 1 / `in_ready` out 1: input handshake
- `in_chan` in CW: channel index, CW = max(1, $clog2(CHANNELS))
- `price_in` in W: signed price
- `out_valid` out 1 / `out_ready` in 1: output handshake
- `out_chan` out CW: channel of the result
- `ret_out`, `ema_fast_out`, `ema_slow_out` out W: signed features
- `warm_out` out 1: the channel's sample count, including this sample, is ≥ `WARMUP`
- `cross_out` out 2: 01 = fast crossed above slow, 10 = fast crossed below slow, 00 = none
- `chan_err` out 1: sticky; set when an out-of-range channel is accepted
- `sat_out` out 1: present only with `FE_SATURATE_EN`; any saturation occurred in this result

## Operation
- Per-channel state: `prev_price`, `ema_f`, `ema_s`, `primed`, `above` (fast>slow), `cnt` (saturates at `WARMUP`). All reset to 0.
- Accept = `in_valid && in_ready`; `in_ready = !out_valid || out_ready`.
- On accept with `in_chan < CHANNELS`:
  - Unprimed channel: ret = 0, EMAs unchanged, `cross_out` = 00. Set `prev_price = price_in`, `primed = 1`, `cnt += 1`.
  - Primed channel:
    - ret = price_in − prev_price
    - ema_f' = ema_f + ((ret − ema_f) >>> FAST_SHIFT)
    - ema_s' = ema_s + ((ret − ema_s) >>> SLOW_SHIFT)
    - new_above = ema_f' > ema_s'
    - `cross_out` = 01 if !above && new_above, 10 if above && !new_above, otherwise 00.
    - `cross_out` is forced to 00 when not warm; `above` is still updated.
  - The output register captures chan, ret, ema_f', ema_s', warm and cross. State is written back the same cycle.
- On accept with `in_chan ≥ CHANNELS`: the sample is consumed and dropped, no output is produced, `chan_err` is set until `rst`.
- Arithmetic: differences and sums are formed in W+1 bits, then reduced to W as described under Configuration. `>>>` is arithmetic (floor).
- `clr`:
  - Zeroes all channel state. Does not touch the output register or `chan_err`.
  - If `clr` and accept occur in the same cycle, the sample is processed as the first sample of a cleared channel.

## Timing
- Latency 1: a result is visible the cycle after accept. Throughput is 1 sample/cycle with `out_ready` held high.
- `out_valid`:
  - Set on valid-channel accept.
  - Held while `out_valid && !out_ready`; outputs stay stable.
  - Cleared on consume without a new valid accept. A dropped out-of-range sample counts as no accept.
- Consume and accept in the same cycle: `out_valid` stays 1 and the register is replaced (back-to-back).
- Reset values: `out_valid` 0, `in_ready` 1, every data output 0, `chan_err` 0, `sat_out` 0.
- `rst` asserted mid-stream: any pending output is lost and all state returns to reset values immediately.

## Configuration
- `FE_SATURATE_EN` defined:
  - Each W+1 → W reduction clamps to [−2^(W−1), 2^(W−1)−1].
  - `sat_out` is present and pulses with any result where a clamp occurred.
- Not defined: two's-complement wrap (low W bits kept), and no `sat_out` port.

## Structure
- Shared package `fxp_pkg` holds:
  - `fe_cross_t` enum: NONE = 00, UP = 01, DOWN = 10
  - per-channel state struct typedef
  - `fxp_sat()` and `fxp_wrap()` functions, parametrised by W
- One sub-module: `fe_ema_update`, combinational, parametrised by shift. It computes ema' and the saturation flag, and is instantiated twice (fast and slow).

## Test plan
- Chan 0, prices 0x00010000 then 0x00030000 → outputs in order:
  - first: ret 0, EMAs 0, warm 0
  - second: ret 0x00020000, fast 0x00008000, slow 0x00001000, warm 1
- Crossover on chan 1, prices 0, 0x00010000, 0 → `cross_out` in order:
  - first sample: 00
  - second sample: 01 (fast 0x4000, slow 0x800)
  - third sample: 10 (fast −0x1000, slow −0x40)
- Interleave chans 0/2/0/2 with distinct ramps → each channel's results match an independent single-channel model. Repeat with the out_ready pattern 1,0,0,1: while stalled, `in_ready`=0 and outputs are stable; no sample is lost or duplicated.
- Chan 3, prices 0x7FFF0000 then 0x80000000 → ret is:
  - with `FE_SATURATE_EN`: 0x80000000 and `sat_out`=1
  - without: 0x00010000
- `in_chan`=5 with CHANNELS=5 → the sample is consumed, there is no `out_valid`, and `chan_err` stays 1. A following chan-0 sample processes normally.
- Pulse `clr` together with a chan-0 accept, then assert `rst` mid-stream → the `clr` sample gives ret 0 and warm 0. After `rst`, `out_valid` is 0 and the next sample on each channel is treated as first.
